tdc_result_serializer: RTL and testbench



---
 rtl/tdc_result_serializer_pkg.sv | 19 +
 rtl/tdc_result_serializer_if.sv | 25 ++
 rtl/tdc_result_serializer_bit_timer.sv | 40 ++++
 rtl/tdc_result_serializer.sv | 147 ++++++++++++++
 tb/tb_tdc_result_serializer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_result_serializer_pkg.sv
// Shared definitions for the TDC readout path: FSM state encoding, the
// default counter width (shared with the upstream counter) and a helper
// that sizes internal counters.
package tdc_pkg;

  localparam int TDC_COUNTER_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdc_result_serializer_if.sv
// Bundle between the TDC controller/counter side and the serializer.
// The master drives the measurement flag, count and overrun clear; the
// slave (serializer) drives the framed serial line and status flags.
interface tdc_result_serializer_if #(
  parameter int COUNTER_BITS = tdc_pkg::TDC_COUNTER_BITS
);
  logic                    running;
  logic [COUNTER_BITS-1:0] count_in;
  logic                    clear_ovr;
  logic                    sdata;
  logic                    sframe;
  logic                    done;
  logic                    busy;
  logic                    overrun;

  modport master (
    output running, count_in, clear_ovr,
    input  sdata, sframe, done, busy, overrun
  );

  modport slave (
    input  running, count_in, clear_ovr,
    output sdata, sframe, done, busy, overrun
  );
endinterface

// File: rtl/tdc_result_serializer_bit_timer.sv
// Bit-period divider: counts clk cycles within one serial bit and raises
// strobe_o on the last cycle of the bit. load_i holds the count at zero so
// the first bit of a frame always gets its full BIT_CYCLES period.
module bit_timer
  import tdc_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic strobe_o
);

  localparam int              DW   = cnt_w(BIT_CYCLES);
  localparam logic [DW-1:0]   LAST = DW'(BIT_CYCLES - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  assign strobe_o = (div_q == LAST);

  // Next divider value: restart on load, wrap at the bit boundary.
  always_comb begin
    div_d = div_q + DW'(1);
    if (load_i || strobe_o) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/tdc_result_serializer.sv
// Captures the TDC count when the measurement window closes and sends it
// MSB-first on a framed serial line. One extra measurement may wait in a
// pending slot; anything beyond that is dropped and flagged as overrun.
module tdc_result_serializer
  import tdc_pkg::*;
#(
  parameter int COUNTER_BITS = TDC_COUNTER_BITS,
  parameter int BIT_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  tdc_result_serializer_if.slave    bus
);

  localparam int            BW       = cnt_w(COUNTER_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(COUNTER_BITS - 1);

  state_e                  state_q, state_d;
  logic                    run_dly_q;
  logic [COUNTER_BITS-1:0] shift_q, shift_d;
  logic [COUNTER_BITS-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    ovr_q, ovr_d;
  logic                    sdata_q, sframe_q, done_q, busy_q;
  logic                    capture;
  logic                    bit_end;

  // Falling edge of the measurement window; count_in is valid this cycle.
  assign capture = run_dly_q & ~bus.running;

  bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q != SHIFT),
    .strobe_o (bit_end)
  );

  // Next-state logic for the FSM, shift register, pending slot and overrun.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bit_d      = bit_q;
    ovr_d      = ovr_q & ~bus.clear_ovr;

    case (state_q)
      IDLE: begin
        if (capture) begin
          shift_d = bus.count_in;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_end) begin
          shift_d = {shift_q[COUNTER_BITS-2:0], 1'b0};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = GAP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
        // Oldest waiting value wins; a newer one is lost.
        if (capture) begin
          if (pend_vld_q) begin
            ovr_d = 1'b1;
          end else begin
            pend_d     = bus.count_in;
            pend_vld_d = 1'b1;
          end
        end
      end

      GAP: begin
        bit_d = '0;
        if (pend_vld_q) begin
          shift_d    = pend_q;
          pend_vld_d = 1'b0;
          state_d    = SHIFT;
          // The slot frees up this cycle, so a coincident capture takes it.
          if (capture) begin
            pend_d     = bus.count_in;
            pend_vld_d = 1'b1;
          end
        end else if (capture) begin
          shift_d = bus.count_in;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and data state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_dly_q  <= 1'b0;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bit_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_dly_q  <= bus.running;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bit_q      <= bit_d;
      ovr_q      <= ovr_d;
    end
  end

  // Registered outputs, decoded from next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdata_q  <= 1'b0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sframe_q <= (state_d == SHIFT);
      sdata_q  <= (state_d == SHIFT) & shift_d[COUNTER_BITS-1];
      done_q   <= (state_d == GAP);
      busy_q   <= (state_d != IDLE) | pend_vld_d;
    end
  end

  assign bus.sdata   = sdata_q;
  assign bus.sframe  = sframe_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_tdc_result_serializer.sv
// Bench for tdc_result_serializer: two instances (BIT_CYCLES 4 and 1),
// a transaction-level schedule model feeding per-instance queues, and a
// negedge monitor that reassembles frames and compares them.
module tb_tdc_result_serializer;
  import tdc_pkg::*;

  localparam int CB  = 8;
  localparam int BC0 = 4;
  localparam int BC1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdc_result_serializer_if #(.COUNTER_BITS(CB)) bus0 ();
  tdc_result_serializer_if #(.COUNTER_BITS(CB)) bus1 ();

  tdc_result_serializer #(.COUNTER_BITS(CB), .BIT_CYCLES(BC0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tdc_result_serializer #(.COUNTER_BITS(CB), .BIT_CYCLES(BC1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [CB-1:0] val;
    int            start;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int   cyc = 0;
  logic rst_edge = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: frames are scheduled back-to-back. A capture at
  // cycle n starts at n+1 or right after the last scheduled frame's gap,
  // unless a frame is already waiting beyond n+1, in which case it is lost.
  int frame_len[2];
  int tail_start[2];
  bit ovr_m[2];
  bit run_prev[2];

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      tail_start[d] = -1000;
      ovr_m[d]      = 1'b0;
      run_prev[d]   = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_capture(input int d, input int n, input logic [CB-1:0] v);
    exp_t e;
    int   after_tail;
    if (tail_start[d] > n + 1) begin
      ovr_m[d] = 1'b1;
    end else begin
      after_tail = tail_start[d] + frame_len[d] + 1;
      e.val   = v;
      e.start = (n + 1 > after_tail) ? n + 1 : after_tail;
      tail_start[d] = e.start;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drive(input int d, input bit run, input logic [CB-1:0] v, input bit clr);
    @(posedge clk);
    #1;
    if (d == 0) begin
      bus0.running = run; bus0.count_in = v; bus0.clear_ovr = clr;
    end else begin
      bus1.running = run; bus1.count_in = v; bus1.clear_ovr = clr;
    end
    if (clr) ovr_m[d] = 1'b0;
    if (run_prev[d] && !run) model_capture(d, cyc, v);
    run_prev[d] = run;
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) drive(d, 1'b0, CB'($urandom), 1'b0);
  endtask

  task automatic fall(input int d, input logic [CB-1:0] v);
    drive(d, 1'b1, CB'($urandom), 1'b0);
    drive(d, 1'b0, v, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus0.running = 1'b0; bus0.clear_ovr = 1'b0;
    bus1.running = 1'b0; bus1.clear_ovr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor state, per instance.
  bit            in_fr[2];
  int            len[2];
  int            badb[2];
  int            badbusy[2];
  int            badd[2];
  logic [CB-1:0] acc[2];
  exp_t          cur[2];
  bit            done_prev[2];
  bit            ovr_prev[2];

  task automatic mon(input int d, input logic sd, input logic sf, input logic dn,
                     input logic bz, input logic ov);
    int bc;
    int i;
    bc = (d == 0) ? BC0 : BC1;
    if (rst_edge) begin
      chk($sformatf("reset outputs d%0d", d), {sd, sf, dn, bz, ov}, 0);
      in_fr[d]     = 1'b0;
      done_prev[d] = 1'b0;
    end else begin
      chk($sformatf("overrun d%0d", d), ov, ovr_prev[d]);
      if (sf) begin
        if (!in_fr[d]) begin
          if (qsize(d) == 0) begin
            chk($sformatf("unexpected frame d%0d", d), 1, 0);
            cur[d].val   = '0;
            cur[d].start = cyc;
          end else begin
            cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("frame start cycle d%0d", d), cyc, cur[d].start);
          end
          in_fr[d]   = 1'b1;
          len[d]     = 0;
          badb[d]    = 0;
          badbusy[d] = 0;
          badd[d]    = 0;
          acc[d]     = '0;
        end
        i = len[d] / bc;
        if (i < CB && sd !== cur[d].val[CB-1-i]) badb[d]++;
        if (len[d] % bc == 0) acc[d] = {acc[d][CB-2:0], sd};
        if (bz !== 1'b1) badbusy[d]++;
        if (dn !== 1'b0) badd[d]++;
        len[d]++;
      end else begin
        if (in_fr[d]) begin
          chk($sformatf("frame length d%0d", d), len[d], CB * bc);
          chk($sformatf("frame data d%0d", d), acc[d], cur[d].val);
          chk($sformatf("bit hold errors d%0d", d), badb[d], 0);
          chk($sformatf("busy low in frame d%0d", d), badbusy[d], 0);
          chk($sformatf("done inside frame d%0d", d), badd[d], 0);
          chk($sformatf("done after last bit d%0d", d), dn, 1);
          in_fr[d] = 1'b0;
        end else begin
          if (dn !== 1'b0) chk($sformatf("stray done d%0d", d), dn, 0);
          if (done_prev[d]) chk($sformatf("busy after gap d%0d", d), bz, 0);
        end
        if (sd !== 1'b0) chk($sformatf("sdata outside frame d%0d", d), sd, 0);
      end
      done_prev[d] = dn;
    end
    ovr_prev[d] = ovr_m[d];
  endtask

  always @(negedge clk) begin
    mon(0, bus0.sdata, bus0.sframe, bus0.done, bus0.busy, bus0.overrun);
    mon(1, bus1.sdata, bus1.sframe, bus1.done, bus1.busy, bus1.overrun);
  end

  task automatic drain(input int d);
    int t;
    t = 0;
    while ((qsize(d) != 0 || in_fr[d]) && t < 600) begin
      idle(d, 1);
      t++;
    end
    chk($sformatf("drain within budget d%0d", d), (t < 600) ? 1 : 0, 1);
    idle(d, 3);
  endtask

  task automatic random_phase(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      drive(d, ($urandom_range(0, 2) == 0), CB'($urandom), ($urandom_range(0, 15) == 0));
    end
    drive(d, 1'b0, CB'($urandom), 1'b0);
    drain(d);
  endtask

  initial begin
    frame_len[0] = CB * BC0;
    frame_len[1] = CB * BC1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      in_fr[d] = 1'b0; done_prev[d] = 1'b0; ovr_prev[d] = 1'b0;
      len[d] = 0; badb[d] = 0; badbusy[d] = 0; badd[d] = 0; acc[d] = '0;
      cur[d].val = '0; cur[d].start = 0;
    end
    bus0.running = 1'b0; bus0.count_in = '0; bus0.clear_ovr = 1'b0;
    bus1.running = 1'b0; bus1.count_in = '0; bus1.clear_ovr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame.
    drive(0, 1'b1, 8'h00, 1'b0);
    drive(0, 1'b1, 8'h00, 1'b0);
    drive(0, 1'b0, 8'hA5, 1'b0);
    drain(0);

    // Back-to-back: second fall during the first frame.
    fall(0, 8'h5A);
    idle(0, 10);
    fall(0, 8'h3C);
    drain(0);

    // Overrun: three falls in one frame, then hold and clear.
    fall(0, 8'h11);
    idle(0, 3);
    fall(0, 8'h22);
    idle(0, 3);
    fall(0, 8'h33);
    drain(0);
    idle(0, 20);
    drive(0, 1'b0, 8'h00, 1'b1);
    idle(0, 5);

    // Capture exactly in the GAP cycle with nothing pending.
    fall(0, 8'h77);
    idle(0, 31);
    fall(0, 8'hF0);
    drain(0);

    // Reset during bit 3, then a clean frame.
    fall(0, 8'hC3);
    idle(0, 13);
    do_reset();
    fall(0, 8'h01);
    drain(0);

    // BIT_CYCLES=1 with a single-cycle running pulse.
    drive(1, 1'b1, 8'h00, 1'b0);
    drive(1, 1'b0, 8'hFF, 1'b0);
    drain(1);

    random_phase(0, 500);
    random_phase(1, 300);

    idle(0, 2);
    chk("final busy d0", bus0.busy, 0);
    chk("final busy d1", bus1.busy, 0);
    chk("leftover frames", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
